// File: rtl/my_serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b - borrow_in (mod 2^WIDTH).
// Operands are captured on accept, then one bit per cycle goes LSB first
// through a single 1-bit full subtractor. The result is held until downstream
// takes it.
//
// state | meaning
// IDLE  | ready_o=1, waiting for valid_i to capture operands
// SHIFT | processing one bit per cycle, WIDTH cycles total
// DONE  | valid_o=1, result held until ready_i
module my_serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             borrow_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              br_q, br_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic bit_d;
  logic bit_br;

  // Single 1-bit full subtractor on the current LSBs and running borrow.
  always_comb begin
    bit_d  = a_q[0] ^ b_q[0] ^ br_q;
    bit_br = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  end

  // Next-state and datapath update; every register holds unless its state acts.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          br_d    = borrow_i;
          diff_d  = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d    = {1'b0, a_q[WIDTH-1:1]};
        b_d    = {1'b0, b_q[WIDTH-1:1]};
        diff_d = {bit_d, diff_q[WIDTH-1:1]};
        br_d   = bit_br;
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset that discards any in-flight operation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake flags decode straight from state; results come from the registers.
  always_comb begin
    ready_o  = (state_q == IDLE);
    valid_o  = (state_q == DONE);
    diff_o   = diff_q;
    borrow_o = br_q;
  end

endmodule

// File: tb/tb_my_serial_subtractor.sv
// Directed bench for my_serial_subtractor (WIDTH=4): vector table plus
// hand-written back-to-back, backpressure and mid-operation reset sequences.
module tb_my_serial_subtractor;

  localparam int W = 4;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         borrow_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] diff_o;
  logic         borrow_o;

  int n_total = 0;
  int n_pass  = 0;

  my_serial_subtractor #(.WIDTH(W)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .a_i      (a_i),
    .b_i      (b_i),
    .borrow_i (borrow_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .diff_o   (diff_o),
    .borrow_o (borrow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Caller sits at a negedge. Accepts one operation, scrambles inputs after
  // accept, checks latency/result, then (if ready_i=1) the return to IDLE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin, input logic [W-1:0] exp_d,
                        input logic exp_bo, input logic rdy);
    int edges;
    int rdy_bad;
    check("ready_before_accept", int'(ready_o), 1);
    a_i      = a;
    b_i      = b;
    borrow_i = bin;
    valid_i  = 1'b1;
    ready_i  = rdy;
    @(negedge clk_i);
    edges    = 1;
    valid_i  = 1'b0;
    a_i      = ~a;
    b_i      = ~b;
    borrow_i = ~bin;
    rdy_bad  = 0;
    while (!valid_o && edges < 20) begin
      if (ready_o) rdy_bad++;
      @(negedge clk_i);
      edges++;
    end
    check("latency_edges", edges, W + 1);
    check("ready_low_in_shift", rdy_bad, 0);
    check("ready_low_in_done", int'(ready_o), 0);
    check("diff", int'(diff_o), int'(exp_d));
    check("borrow", int'(borrow_o), int'(exp_bo));
    if (rdy) begin
      @(negedge clk_i);
      check("valid_one_cycle", int'(valid_o), 0);
      check("ready_back_idle", int'(ready_o), 1);
    end
  endtask

  initial begin
    vecs[0] = '{a: 4'd5,  b: 4'd3,  bin: 1'b0, d: 4'd2,  bo: 1'b0};
    vecs[1] = '{a: 4'd3,  b: 4'd5,  bin: 1'b0, d: 4'd14, bo: 1'b1};
    vecs[2] = '{a: 4'd7,  b: 4'd7,  bin: 1'b1, d: 4'd15, bo: 1'b1};
    vecs[3] = '{a: 4'd14, b: 4'd5,  bin: 1'b0, d: 4'd9,  bo: 1'b0};
    vecs[4] = '{a: 4'd0,  b: 4'd0,  bin: 1'b0, d: 4'd0,  bo: 1'b0};
    vecs[5] = '{a: 4'd15, b: 4'd0,  bin: 1'b1, d: 4'd14, bo: 1'b0};
    vecs[6] = '{a: 4'd0,  b: 4'd15, bin: 1'b1, d: 4'd0,  bo: 1'b1};
    vecs[7] = '{a: 4'd15, b: 4'd15, bin: 1'b0, d: 4'd0,  bo: 1'b0};

    rst_i    = 1'b1;
    valid_i  = 1'b0;
    ready_i  = 1'b1;
    a_i      = '0;
    b_i      = '0;
    borrow_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_ready", int'(ready_o), 1);
    check("rst_valid", int'(valid_o), 0);
    check("rst_diff", int'(diff_o), 0);
    check("rst_borrow", int'(borrow_o), 0);

    // First accept on the very first edge with rst_i low.
    rst_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bo, 1'b1);
    end

    // valid_i held high: one op every 6 edges (IDLE, 4x SHIFT, DONE).
    a_i      = '0;
    b_i      = '0;
    borrow_i = 1'b0;
    valid_i  = 1'b1;
    ready_i  = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_i);
      check("b2b_ready", int'(ready_o), (k % 6 == 0) ? 1 : 0);
      check("b2b_valid", int'(valid_o), (k % 6 == 5) ? 1 : 0);
      if (k % 6 == 5) begin
        check("b2b_diff", int'(diff_o), 0);
        check("b2b_borrow", int'(borrow_o), 0);
      end
    end
    valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);

    // Backpressure: DONE held for 3 extra cycles with ready_i low.
    run_op(4'd14, 4'd5, 1'b0, 4'd9, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("bp_valid", int'(valid_o), 1);
      check("bp_diff", int'(diff_o), 9);
      check("bp_borrow", int'(borrow_o), 0);
      check("bp_ready", int'(ready_o), 0);
    end
    ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_release_valid", int'(valid_o), 0);
    check("bp_release_ready", int'(ready_o), 1);

    // Reset asserted during the 2nd SHIFT cycle.
    a_i      = 4'd5;
    b_i      = 4'd2;
    borrow_i = 1'b1;
    valid_i  = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    @(negedge clk_i);
    rst_i   = 1'b1;
    valid_i = 1'b1;
    ready_i = 1'b1;
    @(negedge clk_i);
    check("midrst_ready", int'(ready_o), 1);
    check("midrst_valid", int'(valid_o), 0);
    check("midrst_diff", int'(diff_o), 0);
    check("midrst_borrow", int'(borrow_o), 0);
    rst_i = 1'b0;
    run_op(4'd9, 4'd4, 1'b0, 4'd5, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
